// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard / stall controller.
package hazard_pkg;

  localparam int unsigned McLatencyDefault = 4;

  typedef enum logic [1:0] {
    StRun,
    StLdStall,
    StMcWait
  } hazard_state_e;

endpackage

// File: rtl/mc_cycle_counter.sv
// Multi-cycle countdown: clear beats load beats decrement; last_o flags a count of one.
module mc_cycle_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle stall and branch-flush controller for a 5-stage pipeline.
// Define STALL_CNT_EN to build the saturating Stall_Count counter; otherwise it reads 0.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_NUM_W  = 3,
  parameter int unsigned MC_LATENCY = McLatencyDefault
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 ID_Valid,
  input  logic [REG_NUM_W-1:0] ID_Rs,
  input  logic [REG_NUM_W-1:0] ID_Rt,
  input  logic                 ID_Uses_Rt,
  input  logic                 ID_Is_MC,
  input  logic [REG_NUM_W-1:0] ID_EX_Rd,
  input  logic                 ID_EX_MemRead,
  input  logic                 Branch_Taken,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Bubble,
  output logic                 MC_Busy,
  output logic [15:0]          Stall_Count
);

  localparam int unsigned CntW = $clog2(MC_LATENCY);

  hazard_state_e state_q, state_d;
  logic          hazard;
  logic          mc_issue;
  logic          cnt_clear, cnt_load, cnt_dec, cnt_last;

  assign hazard = ID_Valid && ID_EX_MemRead &&
                  ((ID_EX_Rd == ID_Rs) || (ID_Uses_Rt && (ID_EX_Rd == ID_Rt)));
  assign mc_issue = ID_Valid && ID_Is_MC;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    MC_Busy      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    if (Branch_Taken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      cnt_clear    = 1'b1;
      state_d      = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            state_d      = StLdStall;
          end else if (mc_issue) begin
            cnt_load = 1'b1;
            state_d  = StMcWait;
          end
        end
        StLdStall: begin
          // The held instruction issues now; a multi-cycle op deferred by the load starts here.
          state_d = StRun;
          if (mc_issue) begin
            cnt_load = 1'b1;
            state_d  = StMcWait;
          end
        end
        StMcWait: begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          MC_Busy      = 1'b1;
          cnt_dec      = 1'b1;
          if (cnt_last) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  mc_cycle_counter #(
    .Width (CntW)
  ) u_mc_cycle_counter (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (CntW'(MC_LATENCY - 1)),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else if (!PC_Write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign Stall_Count = stall_cnt_q;
`else
  assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int unsigned RegW = 3;
  localparam int unsigned Lat  = 4;
`ifdef STALL_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MC_Busy}
  localparam logic [4:0] OutDef   = 5'b11000;
  localparam logic [4:0] OutStall = 5'b00010;
  localparam logic [4:0] OutMc    = 5'b00011;
  localparam logic [4:0] OutBr    = 5'b11110;

  logic            Clk = 1'b0;
  logic            Rst_n = 1'b0;
  logic            ID_Valid, ID_Uses_Rt, ID_Is_MC, ID_EX_MemRead, Branch_Taken;
  logic [RegW-1:0] ID_Rs, ID_Rt, ID_EX_Rd;
  logic            PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MC_Busy;
  logic [15:0]     Stall_Count;
  logic [4:0]      outs;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_mc_left;
  bit m_ld_pend;
  int m_cnt;

  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MC_Busy};

  always #5 Clk = ~Clk;

  hazard_stall_ctrl #(
    .REG_NUM_W  (RegW),
    .MC_LATENCY (Lat)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .ID_Valid      (ID_Valid),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_Uses_Rt    (ID_Uses_Rt),
    .ID_Is_MC      (ID_Is_MC),
    .ID_EX_Rd      (ID_EX_Rd),
    .ID_EX_MemRead (ID_EX_MemRead),
    .Branch_Taken  (Branch_Taken),
    .PC_Write      (PC_Write),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .ID_EX_Bubble  (ID_EX_Bubble),
    .MC_Busy       (MC_Busy),
    .Stall_Count   (Stall_Count)
  );

  task automatic drive(input bit valid, input int rs, input int rt, input bit uses_rt,
                       input bit is_mc, input int rd, input bit memrd, input bit br);
    ID_Valid      = valid;
    ID_Rs         = RegW'(rs);
    ID_Rt         = RegW'(rt);
    ID_Uses_Rt    = uses_rt;
    ID_Is_MC      = is_mc;
    ID_EX_Rd      = RegW'(rd);
    ID_EX_MemRead = memrd;
    Branch_Taken  = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 7, 0, 0);
  endtask

  // Ends 1 time unit after a rising edge with reset released.
  task automatic apply_reset();
    idle();
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    m_mc_left = 0;
    m_ld_pend = 0;
    m_cnt     = 0;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit model_hazard();
    return ID_Valid && ID_EX_MemRead &&
           ((ID_EX_Rd == ID_Rs) || (ID_Uses_Rt && (ID_EX_Rd == ID_Rt)));
  endfunction

  function automatic logic [4:0] model_outs();
    if (Branch_Taken)   return OutBr;
    if (m_mc_left > 0)  return OutMc;
    if (m_ld_pend)      return OutDef;
    if (model_hazard()) return OutStall;
    return OutDef;
  endfunction

  task automatic model_commit();
    logic [4:0] o;
    bit issue;
    o     = model_outs();
    issue = ID_Valid && ID_Is_MC;
    if (CntEn && !o[4] && (m_cnt < 65535)) m_cnt++;
    if (Branch_Taken) begin
      m_mc_left = 0;
      m_ld_pend = 0;
    end else if (m_mc_left > 0) begin
      m_mc_left--;
    end else if (m_ld_pend) begin
      m_ld_pend = 0;
      if (issue) m_mc_left = Lat - 1;
    end else if (model_hazard()) begin
      m_ld_pend = 1;
    end else if (issue) begin
      m_mc_left = Lat - 1;
    end
  endtask

  task automatic test_reset();
    idle();
    Rst_n = 1'b0;
    #2;
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL reset_outs: got=%b want=%b", outs, OutDef);
    end
    total++;
    if (Stall_Count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count: got=%0d want=0", Stall_Count);
    end
    apply_reset();
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL reset_release_outs: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1, 3, 0, 0, 0, 3, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutStall) begin
      bad++;
      $display("FAIL load_use_stall: got=%b want=%b", outs, OutStall);
    end
    next_cycle();
    // Hazard inputs left asserted: the LD_STALL cycle must ignore them.
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL load_use_ldstall: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
    @(negedge Clk);
    total++;
    if (outs !== OutStall) begin
      bad++;
      $display("FAIL load_use_back_in_run: got=%b want=%b", outs, OutStall);
    end
    next_cycle();
    idle();
    next_cycle();
    @(negedge Clk);
    total++;
    if (Stall_Count !== (CntEn ? 16'd2 : 16'd0)) begin
      bad++;
      $display("FAIL load_use_count: got=%0d want=%0d", Stall_Count, CntEn ? 2 : 0);
    end
    next_cycle();
  endtask

  task automatic test_rt_usage();
    apply_reset();
    drive(1, 0, 5, 0, 0, 5, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL rt_unused_no_stall: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
    drive(1, 0, 5, 1, 0, 5, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutStall) begin
      bad++;
      $display("FAIL rt_used_stall: got=%b want=%b", outs, OutStall);
    end
    next_cycle();
    drive(1, 0, 5, 1, 0, 5, 0, 0);
    next_cycle();
    // Register 0 is an ordinary register here; ID_Valid low suppresses detection.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL invalid_no_stall: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutStall) begin
      bad++;
      $display("FAIL r0_stall: got=%b want=%b", outs, OutStall);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_multicycle();
    apply_reset();
    drive(1, 1, 2, 1, 1, 6, 0, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL mc_issue: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
    idle();
    for (int i = 0; i < Lat - 1; i++) begin
      @(negedge Clk);
      total++;
      if (outs !== OutMc) begin
        bad++;
        $display("FAIL mc_wait[%0d]: got=%b want=%b", i, outs, OutMc);
      end
      next_cycle();
    end
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL mc_done: got=%b want=%b", outs, OutDef);
    end
    total++;
    if (Stall_Count !== (CntEn ? 16'(Lat - 1) : 16'd0)) begin
      bad++;
      $display("FAIL mc_count: got=%0d want=%0d", Stall_Count, CntEn ? Lat - 1 : 0);
    end
    next_cycle();
  endtask

  task automatic test_branch_in_mc();
    apply_reset();
    drive(1, 1, 2, 1, 1, 6, 0, 0);
    next_cycle();
    idle();
    next_cycle();
    drive(0, 0, 0, 0, 0, 7, 0, 1);
    @(negedge Clk);
    total++;
    if (outs !== OutBr) begin
      bad++;
      $display("FAIL mc_branch: got=%b want=%b", outs, OutBr);
    end
    next_cycle();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      total++;
      if (outs !== OutDef) begin
        bad++;
        $display("FAIL mc_branch_after[%0d]: got=%b want=%b", i, outs, OutDef);
      end
      next_cycle();
    end
  endtask

  task automatic test_hazard_branch();
    apply_reset();
    drive(1, 4, 0, 0, 0, 4, 1, 1);
    @(negedge Clk);
    total++;
    if (outs !== OutBr) begin
      bad++;
      $display("FAIL hazard_branch: got=%b want=%b", outs, OutBr);
    end
    next_cycle();
    // Still in RUN, so the persisting hazard stalls now.
    drive(1, 4, 0, 0, 0, 4, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutStall) begin
      bad++;
      $display("FAIL hazard_branch_no_ldstall: got=%b want=%b", outs, OutStall);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_hazard_plus_mc();
    apply_reset();
    drive(1, 2, 0, 0, 1, 2, 1, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutStall) begin
      bad++;
      $display("FAIL hz_mc_stall: got=%b want=%b", outs, OutStall);
    end
    next_cycle();
    drive(1, 2, 0, 0, 1, 7, 0, 0);
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL hz_mc_issue: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
    idle();
    for (int i = 0; i < Lat - 1; i++) begin
      @(negedge Clk);
      total++;
      if (outs !== OutMc) begin
        bad++;
        $display("FAIL hz_mc_wait[%0d]: got=%b want=%b", i, outs, OutMc);
      end
      next_cycle();
    end
    @(negedge Clk);
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL hz_mc_done: got=%b want=%b", outs, OutDef);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_mc();
    apply_reset();
    drive(1, 1, 2, 1, 1, 6, 0, 0);
    next_cycle();
    idle();
    next_cycle();
    Rst_n = 1'b0;
    #1;
    total++;
    if (outs !== OutDef) begin
      bad++;
      $display("FAIL mc_reset_outs: got=%b want=%b", outs, OutDef);
    end
    total++;
    if (Stall_Count !== 16'd0) begin
      bad++;
      $display("FAIL mc_reset_count: got=%0d want=0", Stall_Count);
    end
    next_cycle();
    Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total++;
      if (outs !== OutDef) begin
        bad++;
        $display("FAIL mc_reset_after[%0d]: got=%b want=%b", i, outs, OutDef);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [4:0] exp_o;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 6) == 0, $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 15) == 0);
      @(negedge Clk);
      exp_o = model_outs();
      total++;
      if (outs !== exp_o) begin
        bad++;
        $display("FAIL rand_outs cycle %0d: got=%b want=%b", i, outs, exp_o);
      end
      total++;
      if (Stall_Count !== 16'(m_cnt)) begin
        bad++;
        $display("FAIL rand_count cycle %0d: got=%0d want=%0d", i, Stall_Count, m_cnt);
      end
      @(posedge Clk);
      model_commit();
      #1;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rt_usage();
    test_multicycle();
    test_branch_in_mc();
    test_hazard_branch();
    test_hazard_plus_mc();
    test_reset_mid_mc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
